// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480@60 VGA timing constants. Used by vga_controller for its
// parameter defaults and by the pixel generator to size its visible area.
// Provides:
//   H_* / V_*           porch, sync and display lengths in pixels / lines
//   H_TOTAL / V_TOTAL   full line / frame lengths
//   *_SYNC_START/END    inclusive bounds of the active-low sync pulses
//   inWindow()          inclusive range test used for sync decoding
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    // Inclusive range test; both sync pulses are described by closed ranges.
    function automatic logic inWindow(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// ---------------------------------------------------------------------------
// pixel_tick_gen
// Divides the system clock down to the pixel rate by producing a one-cycle
// strobe every CLK_DIV system clocks.
// Ports:
//   clk_i     system clock
//   rst_i     synchronous active-high reset
//   p_tick_o  pixel strobe, high in the last cycle of each divider period
// ---------------------------------------------------------------------------
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic p_tick_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] divCount_q;
    logic [DW-1:0] divCount_d;

    // Divider counts 0..CLK_DIV-1 and wraps; with CLK_DIV=1 it sits at 0.
    always_comb begin
        divCount_d = divCount_q + DW'(1);
        if (divCount_q == LAST) begin
            divCount_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            divCount_q <= '0;
        end else begin
            divCount_q <= divCount_d;
        end
    end

    // Gated by reset so that a divide-by-one build does not strobe in reset.
    assign p_tick_o = !rst_i && (divCount_q == LAST);

endmodule

// File: rtl/vga_controller.sv
// ---------------------------------------------------------------------------
// vga_controller
// Generates VGA raster timing: pixel/line counters, registered active-low
// syncs, visible-area flag and an end-of-frame strobe with a frame counter.
// Ports:
//   sys_clk      system clock (the only clock)
//   sys_rst      synchronous active-high reset
//   hsync/vsync  registered active-low syncs, aligned with x/y
//   video_on     (x,y) lies inside the visible area
//   p_tick       one-cycle pixel strobe
//   x/y          current pixel column / row
//   frame_tick   one-cycle strobe on the last pixel of a frame
//   frame_count  number of completed frames, wraps
// ---------------------------------------------------------------------------
module vga_controller #(
    parameter int CLK_DIV         = 4,
    parameter int SCREEN_WIDTH    = 10,
    parameter int H_DISPLAY       = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT         = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC          = vga_timing_pkg::H_SYNC,
    parameter int H_BACK          = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY       = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT         = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC          = vga_timing_pkg::V_SYNC,
    parameter int V_BACK          = vga_timing_pkg::V_BACK,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       video_on,
    output logic                       p_tick,
    output logic [SCREEN_WIDTH-1:0]    x,
    output logic [SCREEN_WIDTH-1:0]    y,
    output logic                       frame_tick,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

    import vga_timing_pkg::inWindow;

    localparam int SW  = SCREEN_WIDTH;
    localparam int FCW = FRAME_CNT_WIDTH;

    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    logic           pTick;
    logic           lineEnd;
    logic           frameEnd;
    logic [SW-1:0]  hCount_q,     hCount_d;
    logic [SW-1:0]  vCount_q,     vCount_d;
    logic           hsync_q,      hsync_d;
    logic           vsync_q,      vsync_d;
    logic [FCW-1:0] frameCount_q, frameCount_d;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixelTickGen (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .p_tick_o (pTick)
    );

    assign lineEnd  = (hCount_q == SW'(H_TOTAL - 1));
    assign frameEnd = lineEnd && (vCount_q == SW'(V_TOTAL - 1));

    // Counters advance on the pixel strobe; at the frame corner both wrap in
    // the same step so no (0, V_TOTAL-1) position is ever produced. Syncs are
    // decoded from the next-state counts so the registered syncs line up
    // with x/y without a one-pixel lag.
    always_comb begin
        hCount_d     = hCount_q;
        vCount_d     = vCount_q;
        frameCount_d = frameCount_q;
        if (pTick) begin
            if (lineEnd) begin
                hCount_d = '0;
                if (frameEnd) begin
                    vCount_d     = '0;
                    frameCount_d = frameCount_q + FCW'(1);
                end else begin
                    vCount_d = vCount_q + SW'(1);
                end
            end else begin
                hCount_d = hCount_q + SW'(1);
            end
        end
        hsync_d = !inWindow(int'(hCount_d), H_SYNC_START, H_SYNC_END);
        vsync_d = !inWindow(int'(vCount_d), V_SYNC_START, V_SYNC_END);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            hCount_q     <= '0;
            vCount_q     <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            frameCount_q <= '0;
        end else begin
            hCount_q     <= hCount_d;
            vCount_q     <= vCount_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frameCount_q <= frameCount_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign x           = hCount_q;
    assign y           = vCount_q;
    assign p_tick      = pTick;
    assign frame_tick  = pTick && frameEnd;
    assign frame_count = frameCount_q;
    assign video_on    = (hCount_q < SW'(H_DISPLAY)) && (vCount_q < SW'(V_DISPLAY));

endmodule

// File: tb/tb_vga_controller.sv
// ---------------------------------------------------------------------------
// tb_vga_controller
// Three controller builds share one clock: A uses the full 640x480 timing
// with a divide-by-4 pixel clock, B and C use a shrunken raster (25x15) so
// whole frames fit in a short run, with divide-by-1 and divide-by-3 pixel
// clocks respectively. B also has a 2-bit frame counter to exercise wrap.
// Each output is compared every cycle against a position model derived from
// the elapsed cycle count since reset.
// ---------------------------------------------------------------------------
module tb_vga_controller;

    localparam int SHD = 16, SHF = 2, SHS = 4, SHB = 3;
    localparam int SVD = 8,  SVF = 2, SVS = 2, SVB = 3;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        vo;
        logic        pt;
        logic        ft;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        int cyc;
        int x;
        int y;
        bit hs;
        bit vs;
        bit vo;
        bit pt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA, rstB, rstC;
    logic        hsA, vsA, voA, ptA, ftA;
    logic        hsB, vsB, voB, ptB, ftB;
    logic        hsC, vsC, voC, ptC, ftC;
    logic [9:0]  xA, yA, xB, yB, xC, yC;
    logic [15:0] fcA, fcC;
    logic [1:0]  fcB;

    vga_controller #(
        .CLK_DIV (4)
    ) dutA (
        .sys_clk (clk), .sys_rst (rstA), .hsync (hsA), .vsync (vsA),
        .video_on (voA), .p_tick (ptA), .x (xA), .y (yA),
        .frame_tick (ftA), .frame_count (fcA)
    );

    vga_controller #(
        .CLK_DIV (1), .SCREEN_WIDTH (10),
        .H_DISPLAY (SHD), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
        .V_DISPLAY (SVD), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
        .FRAME_CNT_WIDTH (2)
    ) dutB (
        .sys_clk (clk), .sys_rst (rstB), .hsync (hsB), .vsync (vsB),
        .video_on (voB), .p_tick (ptB), .x (xB), .y (yB),
        .frame_tick (ftB), .frame_count (fcB)
    );

    vga_controller #(
        .CLK_DIV (3), .SCREEN_WIDTH (10),
        .H_DISPLAY (SHD), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
        .V_DISPLAY (SVD), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
        .FRAME_CNT_WIDTH (16)
    ) dutC (
        .sys_clk (clk), .sys_rst (rstC), .hsync (hsC), .vsync (vsC),
        .video_on (voC), .p_tick (ptC), .x (xC), .y (yC),
        .frame_tick (ftC), .frame_count (fcC)
    );

    int     testsRun    = 0;
    int     testsFailed = 0;
    longint cA = 0, cB = 0, cC = 0;
    bit     measuring = 1'b0;
    int     hsLowTicksA = 0;
    int     ftCountB = 0;
    int     vsLowC = 0;
    int     rstLeftA = 0, rstLeftB = 0, rstLeftC = 0;

    // Position model: after c clock edges out of reset, floor(c/D) pixels
    // have elapsed; raster position and frame count follow by division.
    function automatic obs_t model(input longint c, input bit inRst, input int d,
                                   input int hd, input int hf, input int hsl, input int hb,
                                   input int vd, input int vf, input int vsl, input int vb,
                                   input int fw);
        obs_t   o;
        longint p, ht, vt, h, v, fr;
        if (inRst) begin
            o = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, vo: 1'b1,
                  pt: 1'b0, ft: 1'b0, fc: 16'd0};
            return o;
        end
        ht   = hd + hf + hsl + hb;
        vt   = vd + vf + vsl + vb;
        p    = c / d;
        h    = p % ht;
        v    = (p / ht) % vt;
        fr   = p / (ht * vt);
        o.x  = 10'(h);
        o.y  = 10'(v);
        o.pt = ((c % d) == longint'(d - 1));
        o.ft = o.pt && (h == ht - 1) && (v == vt - 1);
        o.hs = !((h >= hd + hf) && (h < hd + hf + hsl));
        o.vs = !((v >= vd + vf) && (v < vd + vf + vsl));
        o.vo = (h < hd) && (v < vd);
        o.fc = 16'(fr % (longint'(1) << fw));
        return o;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic compareObs(input string name, input longint c, input obs_t act, input obs_t exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s c=%0d: got x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b ft=%b fc=%0d, expected x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b ft=%b fc=%0d",
                     name, c, act.x, act.y, act.hs, act.vs, act.vo, act.pt, act.ft, act.fc,
                     exp.x, exp.y, exp.hs, exp.vs, exp.vo, exp.pt, exp.ft, exp.fc);
        end
    endtask

    // Per-cycle model comparison for all builds plus the measurement counters.
    task automatic checkOutput();
        obs_t actA, actB, actC;
        actA = '{x: xA, y: yA, hs: hsA, vs: vsA, vo: voA, pt: ptA, ft: ftA, fc: fcA};
        actB = '{x: xB, y: yB, hs: hsB, vs: vsB, vo: voB, pt: ptB, ft: ftB, fc: {14'd0, fcB}};
        actC = '{x: xC, y: yC, hs: hsC, vs: vsC, vo: voC, pt: ptC, ft: ftC, fc: fcC};
        compareObs("A.model", cA, actA, model(cA, rstA, 4, 640, 16, 96, 48, 480, 10, 2, 33, 16));
        compareObs("B.model", cB, actB, model(cB, rstB, 1, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB, 2));
        compareObs("C.model", cC, actC, model(cC, rstC, 3, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB, 16));
        if (measuring) begin
            if (ptA && !hsA) hsLowTicksA++;
            if (ftB) ftCountB++;
            if (!vsC && cC <= 1125) vsLowC++;
        end
    endtask

    // One clock: track edges since reset, then sample 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        cA = rstA ? 0 : cA + 1;
        cB = rstB ? 0 : cB + 1;
        cC = rstC ? 0 : cC + 1;
        #1;
        checkOutput();
    endtask

    // Random short reset pulses on every build.
    task automatic applyStimulus();
        if (rstLeftA > 0) begin rstA = 1'b1; rstLeftA--; end
        else begin rstA = 1'b0; if ($urandom_range(0, 499) == 0) rstLeftA = int'($urandom_range(1, 3)); end
        if (rstLeftB > 0) begin rstB = 1'b1; rstLeftB--; end
        else begin rstB = 1'b0; if ($urandom_range(0, 199) == 0) rstLeftB = int'($urandom_range(1, 3)); end
        if (rstLeftC > 0) begin rstC = 1'b1; rstLeftC--; end
        else begin rstC = 1'b0; if ($urandom_range(0, 199) == 0) rstLeftC = int'($urandom_range(1, 3)); end
    endtask

    initial begin
        vec_t vecs[11];
        bit   found;
        int   hsLowAfter;

        // Landmarks of the first full-size line, in clock edges since release.
        vecs[0]  = '{cyc: 1,    x: 0,   y: 0, hs: 1, vs: 1, vo: 1, pt: 0};
        vecs[1]  = '{cyc: 3,    x: 0,   y: 0, hs: 1, vs: 1, vo: 1, pt: 1};
        vecs[2]  = '{cyc: 4,    x: 1,   y: 0, hs: 1, vs: 1, vo: 1, pt: 0};
        vecs[3]  = '{cyc: 2559, x: 639, y: 0, hs: 1, vs: 1, vo: 1, pt: 1};
        vecs[4]  = '{cyc: 2560, x: 640, y: 0, hs: 1, vs: 1, vo: 0, pt: 0};
        vecs[5]  = '{cyc: 2623, x: 655, y: 0, hs: 1, vs: 1, vo: 0, pt: 1};
        vecs[6]  = '{cyc: 2624, x: 656, y: 0, hs: 0, vs: 1, vo: 0, pt: 0};
        vecs[7]  = '{cyc: 3007, x: 751, y: 0, hs: 0, vs: 1, vo: 0, pt: 1};
        vecs[8]  = '{cyc: 3008, x: 752, y: 0, hs: 1, vs: 1, vo: 0, pt: 0};
        vecs[9]  = '{cyc: 3199, x: 799, y: 0, hs: 1, vs: 1, vo: 0, pt: 1};
        vecs[10] = '{cyc: 3200, x: 0,   y: 1, hs: 1, vs: 1, vo: 1, pt: 0};

        rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
        repeat (3) tick();

        check("A.reset.x", xA, 0);
        check("A.reset.y", yA, 0);
        check("A.reset.hsync", hsA, 1);
        check("A.reset.vsync", vsA, 1);
        check("A.reset.video_on", voA, 1);
        check("A.reset.p_tick", ptA, 0);
        check("B.reset.p_tick", ptB, 0);
        check("B.reset.frame_tick", ftB, 0);

        rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
        measuring = 1'b1;
        for (int i = 0; i < 11; i++) begin
            while (cA < longint'(vecs[i].cyc)) tick();
            check($sformatf("A.vec%0d.x", i), xA, vecs[i].x);
            check($sformatf("A.vec%0d.y", i), yA, vecs[i].y);
            check($sformatf("A.vec%0d.hsync", i), hsA, vecs[i].hs);
            check($sformatf("A.vec%0d.vsync", i), vsA, vecs[i].vs);
            check($sformatf("A.vec%0d.video_on", i), voA, vecs[i].vo);
            check($sformatf("A.vec%0d.p_tick", i), ptA, vecs[i].pt);
        end
        measuring = 1'b0;

        check("A.hsyncLowPixels", hsLowTicksA, 96);
        check("B.frameTicksIn3200", ftCountB, 8);
        check("B.frameCountWrapped", fcB, 0);
        check("C.vsyncLowCyclesFrame0", vsLowC, 150);
        check("C.frameCountAt3200", fcC, 2);

        // Reset in the middle of a horizontal sync pulse.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            if (xC == 10'd20 && yC == 10'd5) found = 1'b1;
        end
        check("C.reachMidSync", found, 1);
        check("C.midSync.hsync", hsC, 0);
        rstC = 1'b1;
        tick();
        check("C.afterReset.x", xC, 0);
        check("C.afterReset.y", yC, 0);
        check("C.afterReset.hsync", hsC, 1);
        rstC = 1'b0;
        hsLowAfter = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!hsC) hsLowAfter++;
        end
        check("C.noResumedSync", hsLowAfter, 0);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/vga_controller.md
VGA_CONTROLLER -- requirements
Module: vga_controller

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving sys_clk cycles per pixel (100 MHz -> 25 MHz pixel rate).
REQ-002 The block SHALL have parameter SCREEN_WIDTH, default 10, giving the x/y coordinate width.
REQ-003 The block SHALL have timing parameters H_DISPLAY 640, H_FRONT 16, H_SYNC 96, H_BACK 48, V_DISPLAY 480, V_FRONT 10, V_SYNC 2, V_BACK 33, all in pixels/lines.
REQ-004 The block SHALL have parameter FRAME_CNT_WIDTH, default 16, giving the frame counter width.
REQ-005 Ports, clock and reset first:
- sys_clk  in  1  sole clock.
- sys_rst  in  1  synchronous, active-high reset.
- hsync  out  1  horizontal sync, active low, registered.
- vsync  out  1  vertical sync, active low, registered.
- video_on  out  1  high while (x,y) is inside the visible area.
- p_tick  out  1  one-sys_clk pixel strobe.
- x  out  SCREEN_WIDTH  current pixel column.
- y  out  SCREEN_WIDTH  current pixel row.
- frame_tick  out  1  one-cycle end-of-frame strobe.
- frame_count  out  FRAME_CNT_WIDTH  completed-frame count.

Function
REQ-006 The clock divider SHALL count 0..CLK_DIV-1 and wrap; p_tick SHALL be high exactly in the cycle where the divider equals CLK_DIV-1.
REQ-007 h_count SHALL advance only on p_tick, running 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters = 800) and wrapping to 0.
REQ-008 v_count SHALL advance only on p_tick with h_count = H_TOTAL-1, running 0..V_TOTAL-1 (V_TOTAL = 525) and wrapping to 0.
REQ-009 x SHALL equal h_count and y SHALL equal v_count, driven directly from the registers, so they change in the cycle after p_tick.
REQ-010 video_on SHALL be (h_count < H_DISPLAY) and (v_count < V_DISPLAY), decoded from the current register values.
REQ-011 hsync SHALL be 0 when h_count is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656,751], else 1.
REQ-012 vsync SHALL be 0 when v_count is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490,491], else 1.
REQ-013 hsync and vsync SHALL be registered and computed from next-count values, so they are cycle-aligned with x and y (zero relative skew).
REQ-014 frame_tick SHALL be high for exactly one sys_clk in the cycle where p_tick=1, h_count=H_TOTAL-1 and v_count=V_TOTAL-1.
REQ-015 frame_count SHALL increment in that same cycle and wrap modulo 2^FRAME_CNT_WIDTH.
REQ-016 At the frame boundary both counters SHALL wrap in the same cycle; no intermediate (0, V_TOTAL-1) state SHALL appear.
REQ-017 CLK_DIV=1 SHALL hold p_tick permanently high, with counters advancing every cycle.
REQ-018 x and y SHALL never exceed H_TOTAL-1 and V_TOTAL-1 respectively.

Reset
REQ-019 While sys_rst=1 at a sys_clk edge, the block SHALL load: divider 0, h_count 0, v_count 0, hsync 1, vsync 1, frame_count 0.
REQ-020 While in reset, p_tick and frame_tick SHALL be 0, and video_on SHALL be 1 (position (0,0)).
REQ-021 Reset asserted mid-line or mid-sync SHALL take effect at the next edge; no partial sync pulse SHALL continue afterwards.
REQ-022 After reset is released, the first p_tick SHALL occur CLK_DIV cycles later.

Structure
REQ-023 The timing constants (H_*/V_* and the derived totals and sync bounds) SHALL live in a shared package vga_timing_pkg, also used by the pixel generator.
REQ-024 The clock divider SHALL be a sub-module named pixel_tick_gen, outputting p_tick.
REQ-025 Everything else SHALL reside in vga_controller, with no other sub-modules.

Verification
REQ-026 Reset then release -> x=0, y=0, hsync=1, vsync=1, video_on=1; first p_tick at cycle 4; x=1 one cycle after that tick.
REQ-027 Run one line -> hsync low for exactly 96 p_ticks starting at x=656; video_on falls at x=640; x wraps 799->0 and y increments once.
REQ-028 Run a full frame -> vsync low for exactly 2 lines (y=490,491); 525 lines per frame; frame_tick pulses once (4-cycle p_tick period: every 1,680,000 sys_clk); frame_count goes 0->1.
REQ-029 Assert sys_rst at x=700, y=300 -> next cycle x=0, y=0, hsync=1; the sync pulse is not resumed.
REQ-030 Preload frame_count to 0xFFFF via a backdoor force -> the next frame_tick wraps it to 0x0000.
REQ-031 CLK_DIV=1 build -> p_tick constantly 1; one line = 800 sys_clk; frame = 420,000 sys_clk.
